// File: rtl/user_strm_pkg.sv
// user_strm_pkg: shared register offsets, constants and
// interrupt FSM type for the user stream loopback FIFO.
package user_strm_pkg;

  // Byte offsets of the register window, relative to REG_BASE
  localparam logic [19:0] CTRL_OFS   = 20'h0_0000;
  localparam logic [19:0] STATUS_OFS = 20'h0_0004;
  localparam logic [19:0] THRESH_OFS = 20'h0_0008;
  localparam logic [19:0] RXCNT_OFS  = 20'h0_000C;

  localparam logic [31:0] UNMAPPED_RD = 32'hDEAD_BEEF;

  localparam int STAT_FULL_BIT  = 16;
  localparam int STAT_EMPTY_BIT = 17;
  localparam int STAT_INTR_BIT  = 18;

  typedef enum logic [1:0] {
    INTR_IDLE     = 2'd0,
    INTR_REQ      = 2'd1,
    INTR_WAIT_CLR = 2'd2
  } intr_state_e;

endpackage

// File: rtl/user_strm_sync_fifo.sv
// user_strm_sync_fifo: first-word-fall-through synchronous FIFO.
// Ports: clk_i/rst_i (sync, active high), push_i/data_i write side,
// pop_i/data_o read side (data_o = head word), clr_i empties the
// FIFO (wins over a coincident push), count_o/full_o/empty_o status.
module user_strm_sync_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic wr_ok;
  logic rd_ok;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign full_o  = count_q[ADDR_W];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // push into a full FIFO is fine when the head leaves the same cycle
  assign wr_ok = push_i && (!full_o || pop_i) && !clr_i;
  assign rd_ok = pop_i && !empty_o && !clr_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      unique case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/user_strm_loopback_fifo.sv
// user_strm_loopback_fifo: PCIe stream loopback endpoint with a
// register window (CTRL/STATUS/THRESH/RXCNT) and threshold interrupt.
// Ports: i_user_clk, i_rst (sync, active high); register bus
// i_user_data/i_user_addr/i_user_wr_req/i_user_rd_req ->
// o_user_data/o_user_rd_ack; host-to-card stream
// i_pcie_str_data_valid/i_pcie_str_data/o_pcie_str_ack; card-to-host
// stream o_pcie_str_data_valid/o_pcie_str_data/i_pcie_str_ack;
// interrupt o_intr_req/i_intr_ack.
// Optional macro USER_STRM_BYTESWAP_EN reverses the bytes of the
// outgoing word.
module user_strm_loopback_fifo
  import user_strm_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 9,
  parameter logic [19:0] REG_BASE = 20'h00100
) (
  input  logic              i_user_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_user_data,
  input  logic [19:0]       i_user_addr,
  input  logic              i_user_wr_req,
  input  logic              i_user_rd_req,
  output logic [31:0]       o_user_data,
  output logic              o_user_rd_ack,
  input  logic              i_pcie_str_data_valid,
  output logic              o_pcie_str_ack,
  input  logic [DATA_W-1:0] i_pcie_str_data,
  output logic              o_pcie_str_data_valid,
  input  logic              i_pcie_str_ack,
  output logic [DATA_W-1:0] o_pcie_str_data,
  output logic              o_intr_req,
  input  logic              i_intr_ack
);

  localparam logic [17:0] CTRL_WA   = 18'((REG_BASE + CTRL_OFS) >> 2);
  localparam logic [17:0] STATUS_WA = 18'((REG_BASE + STATUS_OFS) >> 2);
  localparam logic [17:0] THRESH_WA = 18'((REG_BASE + THRESH_OFS) >> 2);
  localparam logic [17:0] RXCNT_WA  = 18'((REG_BASE + RXCNT_OFS) >> 2);

  logic        en_q, en_d;
  logic [31:0] thresh_q, thresh_d;
  logic [31:0] rxcnt_q, rxcnt_d;
  logic        rd_ack_q, rd_ack_d;
  logic [31:0] rd_data_q, rd_data_d;
  intr_state_e st_q, st_d;

  logic [ADDR_W:0]   fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] head_fmt;

  logic [17:0] word_a;
  logic        hit_ctrl, hit_status, hit_thresh, hit_rxcnt;
  logic        clr;
  logic        push;
  logic        pop;
  logic [31:0] status_v;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^i_user_addr[1:0];

  assign word_a     = i_user_addr[19:2];
  assign hit_ctrl   = (word_a == CTRL_WA);
  assign hit_status = (word_a == STATUS_WA);
  assign hit_thresh = (word_a == THRESH_WA);
  assign hit_rxcnt  = (word_a == RXCNT_WA);

  // clr is a write-one strobe: nothing is stored, it acts at this edge
  assign clr = i_user_wr_req && hit_ctrl && i_user_data[1];

  assign o_pcie_str_ack        = !fifo_full && en_q;
  assign o_pcie_str_data_valid = !fifo_empty;
  assign push = i_pcie_str_data_valid && o_pcie_str_ack;
  assign pop  = o_pcie_str_data_valid && i_pcie_str_ack;

  user_strm_sync_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk_i   (i_user_clk),
    .rst_i   (i_rst),
    .clr_i   (clr),
    .push_i  (push),
    .data_i  (i_pcie_str_data),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef USER_STRM_BYTESWAP_EN
  for (genvar b = 0; b < DATA_W / 8; b++) begin : g_swap
    assign head_fmt[8*b +: 8] = head[DATA_W-8-8*b +: 8];
  end
`else
  assign head_fmt = head;
`endif

  // stale RAM contents never leak out while empty
  assign o_pcie_str_data = fifo_empty ? '0 : head_fmt;

  assign o_intr_req    = (st_q == INTR_REQ);
  assign o_user_rd_ack = rd_ack_q;
  assign o_user_data   = rd_data_q;

  always_comb begin
    status_v = '0;
    status_v[ADDR_W:0]      = fifo_count;
    status_v[STAT_FULL_BIT]  = fifo_full;
    status_v[STAT_EMPTY_BIT] = fifo_empty;
    status_v[STAT_INTR_BIT]  = (st_q == INTR_REQ);
  end

  always_comb begin
    en_d     = en_q;
    thresh_d = thresh_q;
    rxcnt_d  = rxcnt_q;
    if (i_user_wr_req && hit_ctrl) en_d = i_user_data[0];
    if (i_user_wr_req && hit_thresh) thresh_d = i_user_data;
    if (clr) rxcnt_d = '0;
    else if (push) rxcnt_d = rxcnt_q + 32'd1;
  end

  always_comb begin
    rd_ack_d  = i_user_rd_req;
    rd_data_d = '0;
    if (i_user_rd_req) begin
      unique case (1'b1)
        hit_ctrl:   rd_data_d = {31'b0, en_q};
        hit_status: rd_data_d = status_v;
        hit_thresh: rd_data_d = thresh_q;
        hit_rxcnt:  rd_data_d = rxcnt_q;
        default:    rd_data_d = UNMAPPED_RD;
      endcase
    end
  end

  // WAIT_CLR holds off a second request until the count moves away
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      INTR_IDLE:
        if (thresh_q != '0 && rxcnt_d == thresh_q) st_d = INTR_REQ;
      INTR_REQ:
        if (i_intr_ack) st_d = INTR_WAIT_CLR;
      INTR_WAIT_CLR:
        if (rxcnt_d != thresh_q) st_d = INTR_IDLE;
      default:
        st_d = INTR_IDLE;
    endcase
  end

  always_ff @(posedge i_user_clk) begin
    if (i_rst) begin
      en_q      <= 1'b0;
      thresh_q  <= '0;
      rxcnt_q   <= '0;
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
      st_q      <= INTR_IDLE;
    end else begin
      en_q      <= en_d;
      thresh_q  <= thresh_d;
      rxcnt_q   <= rxcnt_d;
      rd_ack_q  <= rd_ack_d;
      rd_data_q <= rd_data_d;
      st_q      <= st_d;
    end
  end

endmodule
